score_keeper: RTL
=================

// Module: score_keeper
// PURPOSE
//   Replaces the plain binary score counter. Runs a per-game BCD score, keeps a
//   high score and drives the 16-bit value shown on the 4-digit 7-seg display.
//   Derives a speed level that the game core uses to scale obstacle speed.
//   Sits between the game core (game_over in) and the 7-seg display driver
//   (disp_num out).
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per score point; >=2
//   BLINK_DIV  25_000_000  clk cycles per score/high-score alternation in OVER; >=2
// PORTS
//   clk          in   1   system clock
//   rst          in   1   asynchronous active-high reset
//   start        in   1   debounced start/restart level; rising edge is the event
//   game_over    in   1   level from game core; high = dinosaur collided
//   score_bcd    out  16  current score, 4 BCD digits, [15:12] = thousands
//   hi_bcd       out  16  best score since reset, BCD
//   disp_num     out  16  value for the display driver
//   new_record   out  1   high in OVER when the last game beat hi_bcd
//   running      out  1   high in RUN
//   speed_level  out  3   min(thousands digit, 7), registered
// BEHAVIOUR
//   Clock/reset: one clock domain. rst is async assert, sync-to-clk deassert
//     is the integrator's job. All outputs are registered.
//   Reset values: state=IDLE; score_bcd=0; hi_bcd=0; disp_num=0;
//     new_record=0; running=0; speed_level=0; prescaler and blink counters=0;
//     start_q (edge detect)=0.
//   start_rise = start & ~start_q; start_q is updated every cycle.
//   FSM states: IDLE, RUN, OVER.
//     IDLE: disp_num=hi_bcd. start_rise -> RUN.
//     RUN: prescaler counts 0..TICK_DIV-1. tick = (prescaler==TICK_DIV-1).
//       On tick, score +1 in BCD. The score saturates at 16'h9999 and does
//       not wrap. disp_num=score_bcd.
//       game_over=1 -> OVER. This beats tick in the same cycle: no increment.
//       start_rise with game_over=0 -> restart: stay in RUN, score=0,
//       prescaler=0.
//     OVER: score frozen. On the entry cycle, compare BCD magnitudes:
//       if score_bcd > hi_bcd then hi_bcd<=score_bcd and new_record<=1,
//       else new_record<=0.
//       disp_num alternates between score_bcd and hi_bcd. It starts with
//       score and toggles every BLINK_DIV cycles; the blink counter is
//       cleared on entry.
//       start_rise -> RUN: score=0, prescaler=0, new_record=0.
//       game_over still high has no effect in OVER.
//   Entry into RUN (either source): score_bcd=0 and prescaler=0 in the same
//     edge that sets running=1. The first increment comes TICK_DIV cycles later.
//   BCD increment: digit ripple. A digit at 9 rolls to 0 and carries to the
//     next digit. The digit value is never >9.
//   Latency: score_bcd changes on the edge after the tick cycle.
//     disp_num and speed_level follow score_bcd one cycle later.
//   Reset mid-game: everything returns to reset values, including hi_bcd.
// STRUCTURE
//   Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, OVER=2'd2),
//     BCD_DIGITS=4, BCD_MAX=16'h9999.
//   Sub-module bcd_digit: one digit. Inputs inc and clr; outputs value[3:0]
//     and carry. Four are chained; saturation is detected at the top level.
//   Top level holds the FSM, prescaler, blink counter, compare and display mux.
// TESTING (bench uses TICK_DIV=4, BLINK_DIV=3)
//   Reset, then start pulse: after 40 cycles in RUN score_bcd=16'h0010,
//     running=1, disp_num tracks score.
//   Preload score to 16'h0099 via ticks, one more tick -> 16'h0100
//     (carry across two digits). At 16'h0999 -> 16'h1000 and speed_level=1.
//   Run to 16'h9999, then 8 more ticks -> score stays 16'h9999 and
//     speed_level=7.
//   game_over asserted on a tick cycle at score 16'h0042 -> OVER, score stays
//     16'h0042, hi_bcd=16'h0042, new_record=1, disp_num toggles
//     0042/0042 every 3 cycles.
//   Second game ends at 16'h0017 -> hi_bcd stays 16'h0042, new_record=0,
//     disp_num alternates 0017/0042.
//   start held high continuously -> exactly one restart. start_rise in RUN
//     clears the score. Async rst mid-RUN -> all outputs 0 at once, with no
//     clock edge needed.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper: FSM encoding, BCD limits,
// and the thousands-digit to speed-level mapping.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StOver = 2'd2
    } state_e;

    localparam int unsigned BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

    function automatic logic [2:0] speed_of(input logic [3:0] thousands);
        return (thousands > 4'd7) ? 3'd7 : thousands[2:0];
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-side bundle of the score keeper: start/game_over in, score and
// display values out.
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic                      start;
    logic                      game_over;
    logic [BCD_DIGITS*4-1:0]   score_bcd;
    logic [BCD_DIGITS*4-1:0]   hi_bcd;
    logic [BCD_DIGITS*4-1:0]   disp_num;
    logic                      new_record;
    logic                      running;
    logic [2:0]                speed_level;

    modport master (
        output start, game_over,
        input  score_bcd, hi_bcd, disp_num, new_record, running, speed_level
    );

    modport slave (
        input  start, game_over,
        output score_bcd, hi_bcd, disp_num, new_record, running, speed_level
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit: clear has priority over increment; 9 rolls to 0 and carries.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (inc) begin
            value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc & ~clr & (value_q == 4'd9);

endmodule

// File: rtl/score_keeper.sv
// Per-game BCD score with saturation, high-score tracking, blinking game-over
// display and a speed level derived from the thousands digit.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic           clk,
    input  logic           rst,
    score_keeper_if.slave  bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);

    state_e            state_q, state_d;
    logic              start_q, start_rise;
    logic [PW-1:0]     presc_q, presc_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              blink_sel_q, blink_sel_d;
    logic              score_clr, score_inc;
    logic [15:0]       score;
    logic [15:0]       hi_q, hi_d;
    logic [15:0]       disp_q, disp_d;
    logic              new_rec_q, new_rec_d;
    logic              running_q;
    logic [2:0]        speed_q;
    logic [BCD_DIGITS:0] carry_chain;
    logic              unused_top_carry;

    assign start_rise = bus.start & ~start_q;

    // Saturation gates the ripple at its source so 9999 never wraps.
    assign carry_chain[0] = score_inc & (score != BCD_MAX);

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .inc   (carry_chain[i]),
            .clr   (score_clr),
            .value (score[4*i +: 4]),
            .carry (carry_chain[i+1])
        );
    end

    assign unused_top_carry = carry_chain[BCD_DIGITS];

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        blink_d     = blink_q;
        blink_sel_d = blink_sel_q;
        hi_d        = hi_q;
        new_rec_d   = new_rec_q;
        score_clr   = 1'b0;
        score_inc   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d   = StRun;
                    score_clr = 1'b1;
                    presc_d   = '0;
                end
            end
            StRun: begin
                if (bus.game_over) begin
                    state_d     = StOver;
                    blink_d     = '0;
                    blink_sel_d = 1'b0;
                    // Digits never exceed 9, so binary compare equals BCD magnitude.
                    if (score > hi_q) begin
                        hi_d      = score;
                        new_rec_d = 1'b1;
                    end else begin
                        new_rec_d = 1'b0;
                    end
                end else if (start_rise) begin
                    score_clr = 1'b1;
                    presc_d   = '0;
                end else if (presc_q == PW'(TICK_DIV - 1)) begin
                    score_inc = 1'b1;
                    presc_d   = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StOver: begin
                if (start_rise) begin
                    state_d   = StRun;
                    score_clr = 1'b1;
                    presc_d   = '0;
                    new_rec_d = 1'b0;
                end else if (blink_q == BW'(BLINK_DIV - 1)) begin
                    blink_d     = '0;
                    blink_sel_d = ~blink_sel_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (state_q)
            StRun:   disp_d = score;
            StOver:  disp_d = blink_sel_q ? hi_q : score;
            default: disp_d = hi_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            presc_q     <= '0;
            blink_q     <= '0;
            blink_sel_q <= 1'b0;
            hi_q        <= '0;
            disp_q      <= '0;
            new_rec_q   <= 1'b0;
            running_q   <= 1'b0;
            speed_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            presc_q     <= presc_d;
            blink_q     <= blink_d;
            blink_sel_q <= blink_sel_d;
            hi_q        <= hi_d;
            disp_q      <= disp_d;
            new_rec_q   <= new_rec_d;
            running_q   <= (state_d == StRun);
            speed_q     <= speed_of(score[15:12]);
        end
    end

    assign bus.score_bcd   = score;
    assign bus.hi_bcd      = hi_q;
    assign bus.disp_num    = disp_q;
    assign bus.new_record  = new_rec_q;
    assign bus.running     = running_q;
    assign bus.speed_level = speed_q;

endmodule
